// File: rtl/uvmt_obi_st_rst_ctrl.sv
// Reset controller for the OBI self-test bench: stretches the incoming reset,
// releases NUM_OUT domains one after another, services soft-reset requests
// and reports uptime and the number of soft resets taken.
module uvmt_obi_st_rst_ctrl #(
  parameter int NUM_OUT           = 3,
  parameter int MIN_ASSERT_CYCLES = 8,
  parameter int STAGGER_CYCLES    = 4,
  parameter int CNT_W             = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               soft_rst_req,
  output logic               soft_rst_ack,
  output logic [NUM_OUT-1:0] rst_out,
  output logic [NUM_OUT-1:0] rst_out_n,
  output logic               all_released,
  output logic [CNT_W-1:0]   uptime,
  output logic [7:0]         rst_count,
  output logic [1:0]         state
);

  localparam int CNT_MAX = (MIN_ASSERT_CYCLES > STAGGER_CYCLES) ? MIN_ASSERT_CYCLES : STAGGER_CYCLES;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int SW      = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;

  localparam logic [CW-1:0] ASSERT_LAST  = CW'(MIN_ASSERT_CYCLES - 1);
  localparam logic [CW-1:0] STAGGER_LAST = CW'(STAGGER_CYCLES - 1);
  localparam logic [SW-1:0] STAGE_LAST   = SW'(NUM_OUT - 1);

  typedef enum logic [1:0] {
    ST_ASSERT  = 2'd0,
    ST_RELEASE = 2'd1,
    ST_RUN     = 2'd2
  } state_e;

  state_e             cur_state;
  state_e             next_state;
  logic [CW-1:0]      cnt;
  logic [CW-1:0]      cnt_next;
  logic [SW-1:0]      stage;
  logic [SW-1:0]      stage_next;
  logic [NUM_OUT-1:0] rst_out_d;
  logic               ack_d;
  logic               all_rel_d;
  logic [CNT_W-1:0]   uptime_d;
  logic [7:0]         rst_count_d;
  logic               soft_take;

  assign soft_take = (cur_state == ST_RUN) && soft_rst_req;
  assign state     = cur_state;

  // State register plus every registered output; reset wins over all inputs
  always_ff @(posedge clk) begin
    if (reset) begin
      cur_state    <= ST_ASSERT;
      cnt          <= '0;
      stage        <= '0;
      rst_out      <= '1;
      rst_out_n    <= '0;
      soft_rst_ack <= 1'b0;
      all_released <= 1'b0;
      uptime       <= '0;
      rst_count    <= '0;
    end else begin
      cur_state    <= next_state;
      cnt          <= cnt_next;
      stage        <= stage_next;
      rst_out      <= rst_out_d;
      rst_out_n    <= ~rst_out_d;
      soft_rst_ack <= ack_d;
      all_released <= all_rel_d;
      uptime       <= uptime_d;
      rst_count    <= rst_count_d;
    end
  end

  // Next-state logic: stretch counter, stagger counter and soft-reset re-entry
  always_comb begin
    next_state = cur_state;
    cnt_next   = cnt;
    stage_next = stage;
    case (cur_state)
      ST_ASSERT: begin
        if (cnt == ASSERT_LAST) begin
          cnt_next   = '0;
          stage_next = '0;
          next_state = (NUM_OUT == 1) ? ST_RUN : ST_RELEASE;
        end else begin
          cnt_next = cnt + CW'(1);
        end
      end
      ST_RELEASE: begin
        if (cnt == STAGGER_LAST) begin
          cnt_next   = '0;
          stage_next = stage + SW'(1);
          if (stage_next == STAGE_LAST) begin
            next_state = ST_RUN;
          end
        end else begin
          cnt_next = cnt + CW'(1);
        end
      end
      ST_RUN: begin
        if (soft_take) begin
          next_state = ST_ASSERT;
          cnt_next   = '0;
          stage_next = '0;
        end
      end
      default: begin
        next_state = ST_ASSERT;
        cnt_next   = '0;
        stage_next = '0;
      end
    endcase
  end

  // Output logic: values the outputs take on the next edge
  always_comb begin
    rst_out_d   = rst_out;
    ack_d       = 1'b0;
    uptime_d    = uptime;
    rst_count_d = rst_count;
    case (cur_state)
      ST_ASSERT: begin
        rst_out_d = '1;
        if (cnt == ASSERT_LAST) begin
          rst_out_d[0] = 1'b0;
        end
      end
      ST_RELEASE: begin
        if (cnt == STAGGER_LAST) begin
          for (int i = 0; i < NUM_OUT; i++) begin
            if (SW'(i) == stage_next) begin
              rst_out_d[i] = 1'b0;
            end
          end
        end
      end
      ST_RUN: begin
        if (soft_take) begin
          rst_out_d   = '1;
          ack_d       = 1'b1;
          uptime_d    = '0;
          rst_count_d = (rst_count == 8'hFF) ? rst_count : rst_count + 8'd1;
        end else begin
          uptime_d = (uptime == {CNT_W{1'b1}}) ? uptime : uptime + CNT_W'(1);
        end
      end
      default: begin
        rst_out_d = '1;
      end
    endcase
    all_rel_d = ~|rst_out_d;
  end

endmodule

// File: tb/tb_uvmt_obi_st_rst_ctrl.sv
// Self-checking bench for uvmt_obi_st_rst_ctrl: three instances (default,
// single fast domain, narrow uptime) checked every cycle against a timeline
// model, plus hand-computed literal checks at the interesting edges.
module tb_uvmt_obi_st_rst_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic soft_rst_req = 1'b0;

  int checks = 0;
  int errors = 0;

  logic        a_ack, a_all;
  logic [2:0]  a_rst_out, a_rst_out_n;
  logic [31:0] a_uptime;
  logic [7:0]  a_cnt;
  logic [1:0]  a_state;

  logic        b_ack, b_all;
  logic        b_rst_out, b_rst_out_n;
  logic [31:0] b_uptime;
  logic [7:0]  b_cnt;
  logic [1:0]  b_state;

  logic        c_ack, c_all;
  logic [2:0]  c_rst_out, c_rst_out_n;
  logic [3:0]  c_uptime;
  logic [7:0]  c_cnt;
  logic [1:0]  c_state;

  uvmt_obi_st_rst_ctrl #(.NUM_OUT(3), .MIN_ASSERT_CYCLES(8), .STAGGER_CYCLES(4), .CNT_W(32)) dut_a (
    .clk(clk), .reset(reset), .soft_rst_req(soft_rst_req), .soft_rst_ack(a_ack),
    .rst_out(a_rst_out), .rst_out_n(a_rst_out_n), .all_released(a_all),
    .uptime(a_uptime), .rst_count(a_cnt), .state(a_state));

  uvmt_obi_st_rst_ctrl #(.NUM_OUT(1), .MIN_ASSERT_CYCLES(1), .STAGGER_CYCLES(4), .CNT_W(32)) dut_b (
    .clk(clk), .reset(reset), .soft_rst_req(soft_rst_req), .soft_rst_ack(b_ack),
    .rst_out(b_rst_out), .rst_out_n(b_rst_out_n), .all_released(b_all),
    .uptime(b_uptime), .rst_count(b_cnt), .state(b_state));

  uvmt_obi_st_rst_ctrl #(.NUM_OUT(3), .MIN_ASSERT_CYCLES(8), .STAGGER_CYCLES(4), .CNT_W(4)) dut_c (
    .clk(clk), .reset(reset), .soft_rst_req(soft_rst_req), .soft_rst_ack(c_ack),
    .rst_out(c_rst_out), .rst_out_n(c_rst_out_n), .all_released(c_all),
    .uptime(c_uptime), .rst_count(c_cnt), .state(c_state));

  // Free-running bench clock
  always #5 clk = ~clk;

  function automatic int p_nout(input int k);
    return (k == 1) ? 1 : 3;
  endfunction

  function automatic int p_min(input int k);
    return (k == 1) ? 1 : 8;
  endfunction

  function automatic int p_stag(input int k);
    return (k >= 0) ? 4 : 4;
  endfunction

  function automatic longint p_upmax(input int k);
    return (k == 2) ? 64'd15 : 64'hFFFF_FFFF;
  endfunction

  function automatic int p_total(input int k);
    return p_min(k) + (p_nout(k) - 1) * p_stag(k);
  endfunction

  // Model: m_t = edges since the sequence (re)started, saturating at the total latency
  int     m_t   [3];
  longint m_up  [3];
  int     m_cnt [3];
  logic   m_ack [3];
  bit     m_valid = 1'b0;

  function automatic logic [2:0] exp_rst(input int k);
    logic [2:0] r;
    r = 3'b000;
    for (int i = 0; i < p_nout(k); i++) begin
      if (m_t[k] < p_min(k) + i * p_stag(k)) r[i] = 1'b1;
    end
    return r;
  endfunction

  function automatic logic [2:0] out_mask(input int k);
    return (p_nout(k) == 1) ? 3'b001 : 3'b111;
  endfunction

  function automatic logic [1:0] exp_state(input int k);
    if (m_t[k] < p_min(k)) return 2'd0;
    if (m_t[k] < p_total(k)) return 2'd1;
    return 2'd2;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at time %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic req, input int n);
    reset = rst;
    soft_rst_req = req;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic compare_inst(input int k, input logic [2:0] rst, input logic [2:0] rstn, input logic ack,
                              input logic all, input logic [31:0] up, input logic [7:0] cnt, input logic [1:0] st);
    logic [2:0] e;
    e = exp_rst(k);
    checkOutput($sformatf("rst_out_%0d", k), {29'b0, rst}, {29'b0, e});
    checkOutput($sformatf("rst_out_n_%0d", k), {29'b0, rstn}, {29'b0, ~e & out_mask(k)});
    checkOutput($sformatf("ack_%0d", k), {31'b0, ack}, {31'b0, m_ack[k]});
    checkOutput($sformatf("all_released_%0d", k), {31'b0, all}, {31'b0, (m_t[k] >= p_total(k))});
    checkOutput($sformatf("uptime_%0d", k), up, m_up[k][31:0]);
    checkOutput($sformatf("rst_count_%0d", k), {24'b0, cnt}, m_cnt[k]);
    checkOutput($sformatf("state_%0d", k), {30'b0, st}, {30'b0, exp_state(k)});
  endtask

  // Advance the timeline model on every rising edge from the sampled inputs
  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (reset) begin
        m_t[k] = 0; m_up[k] = 0; m_cnt[k] = 0; m_ack[k] = 1'b0;
      end else if (m_valid) begin
        if (m_t[k] >= p_total(k)) begin
          if (soft_rst_req) begin
            m_t[k] = 0; m_up[k] = 0; m_ack[k] = 1'b1;
            m_cnt[k] = (m_cnt[k] < 255) ? m_cnt[k] + 1 : 255;
          end else begin
            m_ack[k] = 1'b0;
            m_up[k] = (m_up[k] < p_upmax(k)) ? m_up[k] + 1 : p_upmax(k);
          end
        end else begin
          m_t[k] = m_t[k] + 1;
          m_ack[k] = 1'b0;
        end
      end
    end
    if (reset) m_valid = 1'b1;
  end

  // Compare all three instances against the model on every falling edge
  always @(negedge clk) begin
    if (m_valid) begin
      compare_inst(0, a_rst_out, a_rst_out_n, a_ack, a_all, a_uptime, a_cnt, a_state);
      compare_inst(1, {2'b0, b_rst_out}, {2'b0, b_rst_out_n}, b_ack, b_all, b_uptime, b_cnt, b_state);
      compare_inst(2, c_rst_out, c_rst_out_n, c_ack, c_all, {28'b0, c_uptime}, c_cnt, c_state);
    end
  end

  // Watchdog so the run always ends
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed stimulus with hand-computed expectations at key edges
  initial begin
    applyStimulus(1'b1, 1'b0, 3);
    checkOutput("lit_e0_rst_out", {29'b0, a_rst_out}, 32'h7);
    checkOutput("lit_e0_rst_out_n", {29'b0, a_rst_out_n}, 32'h0);
    checkOutput("lit_e0_state", {30'b0, a_state}, 32'd0);
    checkOutput("lit_e0_uptime", a_uptime, 32'd0);
    checkOutput("lit_e0_b_rst", {31'b0, b_rst_out}, 32'd1);

    applyStimulus(1'b0, 1'b0, 1);
    checkOutput("lit_e1_b_rst", {31'b0, b_rst_out}, 32'd0);
    checkOutput("lit_e1_b_state", {30'b0, b_state}, 32'd2);
    checkOutput("lit_e1_b_all", {31'b0, b_all}, 32'd1);

    applyStimulus(1'b0, 1'b0, 6);
    checkOutput("lit_e7_rst_out", {29'b0, a_rst_out}, 32'h7);
    applyStimulus(1'b0, 1'b0, 1);
    checkOutput("lit_e8_rst_out", {29'b0, a_rst_out}, 32'h6);
    checkOutput("lit_e8_state", {30'b0, a_state}, 32'd1);
    applyStimulus(1'b0, 1'b0, 4);
    checkOutput("lit_e12_rst_out", {29'b0, a_rst_out}, 32'h4);
    applyStimulus(1'b0, 1'b0, 3);
    checkOutput("lit_e15_all", {31'b0, a_all}, 32'd0);
    applyStimulus(1'b0, 1'b0, 1);
    checkOutput("lit_e16_rst_out", {29'b0, a_rst_out}, 32'h0);
    checkOutput("lit_e16_all", {31'b0, a_all}, 32'd1);
    checkOutput("lit_e16_state", {30'b0, a_state}, 32'd2);
    applyStimulus(1'b0, 1'b0, 1);
    checkOutput("lit_e17_uptime", a_uptime, 32'd1);
    applyStimulus(1'b0, 1'b0, 19);
    checkOutput("lit_e36_uptime", a_uptime, 32'd20);
    checkOutput("lit_e36_c_uptime_sat", {28'b0, c_uptime}, 32'd15);

    applyStimulus(1'b0, 1'b1, 1);
    checkOutput("lit_soft_ack", {31'b0, a_ack}, 32'd1);
    checkOutput("lit_soft_rst_out", {29'b0, a_rst_out}, 32'h7);
    checkOutput("lit_soft_uptime", a_uptime, 32'd0);
    checkOutput("lit_soft_count", {24'b0, a_cnt}, 32'd1);
    applyStimulus(1'b0, 1'b0, 1);
    checkOutput("lit_soft_ack_pulse", {31'b0, a_ack}, 32'd0);
    applyStimulus(1'b0, 1'b0, 14);
    checkOutput("lit_soft_e15_all", {31'b0, a_all}, 32'd0);
    applyStimulus(1'b0, 1'b0, 1);
    checkOutput("lit_soft_e16_all", {31'b0, a_all}, 32'd1);

    applyStimulus(1'b0, 1'b1, 1);
    checkOutput("lit_hold_ack1", {31'b0, a_ack}, 32'd1);
    checkOutput("lit_hold_count2", {24'b0, a_cnt}, 32'd2);
    applyStimulus(1'b0, 1'b1, 16);
    checkOutput("lit_hold_gap_ack", {31'b0, a_ack}, 32'd0);
    applyStimulus(1'b0, 1'b1, 1);
    checkOutput("lit_hold_ack2", {31'b0, a_ack}, 32'd1);
    checkOutput("lit_hold_count3", {24'b0, a_cnt}, 32'd3);
    applyStimulus(1'b0, 1'b1, 4400);
    checkOutput("lit_count_sat_a", {24'b0, a_cnt}, 32'd255);
    checkOutput("lit_count_sat_b", {24'b0, b_cnt}, 32'd255);
    applyStimulus(1'b0, 1'b0, 20);
    applyStimulus(1'b0, 1'b1, 1);
    checkOutput("lit_sat_ack", {31'b0, a_ack}, 32'd1);
    checkOutput("lit_sat_hold", {24'b0, a_cnt}, 32'd255);

    applyStimulus(1'b0, 1'b0, 9);
    checkOutput("lit_mid_rst_out", {29'b0, a_rst_out}, 32'h6);
    checkOutput("lit_mid_state", {30'b0, a_state}, 32'd1);
    applyStimulus(1'b1, 1'b0, 1);
    checkOutput("lit_mid_reset_rst_out", {29'b0, a_rst_out}, 32'h7);
    checkOutput("lit_mid_reset_count", {24'b0, a_cnt}, 32'd0);
    checkOutput("lit_mid_reset_state", {30'b0, a_state}, 32'd0);
    applyStimulus(1'b0, 1'b0, 15);
    checkOutput("lit_restart_e15_rst_out", {29'b0, a_rst_out}, 32'h4);
    checkOutput("lit_restart_e15_all", {31'b0, a_all}, 32'd0);
    applyStimulus(1'b0, 1'b0, 1);
    checkOutput("lit_restart_e16_all", {31'b0, a_all}, 32'd1);

    applyStimulus(1'b0, 1'b0, 3);
    applyStimulus(1'b1, 1'b1, 1);
    checkOutput("lit_race_ack", {31'b0, a_ack}, 32'd0);
    checkOutput("lit_race_count", {24'b0, a_cnt}, 32'd0);
    checkOutput("lit_race_rst_out", {29'b0, a_rst_out}, 32'h7);
    applyStimulus(1'b0, 1'b0, 20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
